// File: rtl/mole_hit_judge.sv
// mole_hit_judge
//   Consumer side of the whack-a-mole position interface. Follows the mole
//   position generator, lights the LED of the current mole, judges the five
//   debounced buttons against it, keeps a BCD hit score and a saturating
//   miss count, and asks the generator for a new position after a hit.
//
// Parameters
//   TIMEOUT             cycles spent in WAIT_NEW before the change request
//                       is re-issued (1..65535)
//
// Ports
//   i_clk               system clock
//   i_rst_n             asynchronous active-low reset
//   i_mole_position     generator mole index, 0..4 valid, 5..7 = no mole
//   i_position_changed  one-cycle pulse, i_mole_position valid with it
//   i_btn               debounced button levels, bit k = hole k
//   o_change_position   one-cycle request for a new position
//   o_mole_onehot       LED drive, one-hot of the latched position in ARMED
//   o_mole_valid        high only in ARMED
//   o_hit / o_miss      one-cycle pulses per scored hit / wrong press
//   o_score_tens/ones   BCD hit count, saturates at 99
//   o_misses            binary miss count, saturates at 15
//   o_dbg_state         current FSM state (0 IDLE, 1 ARMED, 2 WAIT_NEW)
//
// Handshake: o_change_position is a single-cycle request with no ready;
// the generator answers some cycles later with a single-cycle
// i_position_changed strobe carrying i_mole_position in the same cycle.
// Nothing is ever held waiting on a ready signal.

module mole_hit_judge #(
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_mole_position,
  input  logic       i_position_changed,
  input  logic [4:0] i_btn,
  output logic       o_change_position,
  output logic [4:0] o_mole_onehot,
  output logic       o_mole_valid,
  output logic       o_hit,
  output logic       o_miss,
  output logic [3:0] o_score_tens,
  output logic [3:0] o_score_ones,
  output logic [3:0] o_misses,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    WAIT_NEW = 2'd2
  } state_t;

  state_t      r_state;
  logic [4:0]  r_btn_q;
  logic [2:0]  r_pos;
  logic [15:0] r_timer;
  logic        r_change;
  logic [4:0]  r_onehot;
  logic        r_valid;
  logic        r_hit;
  logic        r_miss;
  logic [3:0]  r_tens;
  logic [3:0]  r_ones;
  logic [3:0]  r_misses;

  logic [4:0]  w_rise;
  logic        w_pos_ok;
  logic [4:0]  w_new_onehot;
  logic [4:0]  w_cur_onehot;

  assign w_rise       = i_btn & ~r_btn_q;
  assign w_pos_ok     = (i_mole_position < 3'd5);
  assign w_new_onehot = w_pos_ok ? (5'b00001 << i_mole_position) : 5'b00000;
  assign w_cur_onehot = 5'b00001 << r_pos;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      // All ones so a button held through reset is not seen as a press.
      r_btn_q  <= 5'b11111;
      r_pos    <= 3'd0;
      r_timer  <= 16'd0;
      r_change <= 1'b0;
      r_onehot <= 5'b00000;
      r_valid  <= 1'b0;
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;
      r_tens   <= 4'd0;
      r_ones   <= 4'd0;
      r_misses <= 4'd0;
    end else begin
      r_btn_q  <= i_btn;
      r_change <= 1'b0;
      r_hit    <= 1'b0;
      r_miss   <= 1'b0;

      case (r_state)
        IDLE: begin
          if (i_position_changed && w_pos_ok) begin
            r_pos    <= i_mole_position;
            r_state  <= ARMED;
            r_valid  <= 1'b1;
            r_onehot <= w_new_onehot;
          end
        end

        ARMED: begin
          // A new position overrides any press in the same cycle.
          if (i_position_changed) begin
            if (w_pos_ok) begin
              r_pos    <= i_mole_position;
              r_onehot <= w_new_onehot;
            end else begin
              r_state  <= IDLE;
              r_valid  <= 1'b0;
              r_onehot <= 5'b00000;
            end
          end else if (w_rise == w_cur_onehot) begin
            r_hit    <= 1'b1;
            r_change <= 1'b1;
            r_state  <= WAIT_NEW;
            r_timer  <= 16'd0;
            r_valid  <= 1'b0;
            r_onehot <= 5'b00000;
            if (!(r_tens == 4'd9 && r_ones == 4'd9)) begin
              if (r_ones == 4'd9) begin
                r_ones <= 4'd0;
                r_tens <= r_tens + 4'd1;
              end else begin
                r_ones <= r_ones + 4'd1;
              end
            end
          end else if (w_rise != 5'b00000) begin
            // Wrong button, or the right one together with a wrong one.
            r_miss <= 1'b1;
            if (r_misses != 4'd15) begin
              r_misses <= r_misses + 4'd1;
            end
          end
        end

        WAIT_NEW: begin
          if (i_position_changed) begin
            if (w_pos_ok) begin
              r_pos    <= i_mole_position;
              r_state  <= ARMED;
              r_valid  <= 1'b1;
              r_onehot <= w_new_onehot;
            end else begin
              r_state  <= IDLE;
            end
          end else if (r_timer == TIMEOUT - 16'd1) begin
            // Generator seems to have missed the request; ask again.
            r_change <= 1'b1;
            r_timer  <= 16'd0;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end

        default: begin
          r_state  <= IDLE;
          r_valid  <= 1'b0;
          r_onehot <= 5'b00000;
        end
      endcase
    end
  end

  assign o_change_position = r_change;
  assign o_mole_onehot     = r_onehot;
  assign o_mole_valid      = r_valid;
  assign o_hit             = r_hit;
  assign o_miss            = r_miss;
  assign o_score_tens      = r_tens;
  assign o_score_ones      = r_ones;
  assign o_misses          = r_misses;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_mole_hit_judge.sv
// Directed testbench for mole_hit_judge with TIMEOUT = 4.
// Inputs change 1 ns after a rising edge; outputs are checked at the same
// point, i.e. they show the result of the edge just taken.

module tb_mole_hit_judge;

  logic       clk;
  logic       rst_n;
  logic [2:0] mole_position;
  logic       position_changed;
  logic [4:0] btn;
  logic       change_position;
  logic [4:0] mole_onehot;
  logic       mole_valid;
  logic       hit;
  logic       miss;
  logic [3:0] score_tens;
  logic [3:0] score_ones;
  logic [3:0] misses;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  mole_hit_judge #(.TIMEOUT(16'd4)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_mole_position    (mole_position),
    .i_position_changed (position_changed),
    .i_btn              (btn),
    .o_change_position  (change_position),
    .o_mole_onehot      (mole_onehot),
    .o_mole_valid       (mole_valid),
    .o_hit              (hit),
    .o_miss             (miss),
    .o_score_tens       (score_tens),
    .o_score_ones       (score_ones),
    .o_misses           (misses),
    .o_dbg_state        (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pos(input logic [2:0] p);
    mole_position    = p;
    position_changed = 1'b1;
    step();
    position_changed = 1'b0;
  endtask

  function automatic logic [31:0] all_outs();
    return {11'd0, change_position, mole_onehot, mole_valid, hit, miss,
            score_tens, score_ones, misses};
  endfunction

  int exp_score;
  int exp_miss;

  initial begin
    rst_n = 1'b0;
    mole_position = 3'd0;
    position_changed = 1'b0;
    btn = 5'b00100;
    exp_score = 0;
    exp_miss = 0;

    // Reset with button 2 held.
    #12;
    check("reset_outs", all_outs(), 32'd0);
    check("reset_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    rst_n = 1'b1;
    step();
    check("idle_after_reset", {30'd0, dbg_state}, {30'd0, S_IDLE});

    send_pos(3'd2);
    check("armed_onehot", {27'd0, mole_onehot}, 32'h04);
    check("armed_valid", {31'd0, mole_valid}, 32'd1);
    step();
    check("held_no_hit", {31'd0, hit}, 32'd0);
    btn = 5'b00000;
    step();
    check("release_no_hit", {31'd0, hit}, 32'd0);
    btn = 5'b00100;
    step();
    exp_score = 1;
    check("repress_hit", {31'd0, hit}, 32'd1);
    check("repress_change", {31'd0, change_position}, 32'd1);
    check("score_0_1", {24'd0, score_tens, score_ones}, 32'h01);
    check("wait_state", {30'd0, dbg_state}, {30'd0, S_WAIT});
    check("wait_valid", {31'd0, mole_valid}, 32'd0);

    // Timeout re-requests every 4 cycles; presses in WAIT_NEW ignored.
    for (int k = 1; k <= 8; k++) begin
      btn = (k == 2 || k == 5) ? 5'b00011 : 5'b00000;
      step();
      check("timeout_change", {31'd0, change_position}, (k % 4 == 0) ? 32'd1 : 32'd0);
      check("wait_no_hitmiss", {30'd0, hit, miss}, 32'd0);
    end
    btn = 5'b00000;

    // Miss on two buttons including the right one, then hit.
    send_pos(3'd3);
    check("armed3_onehot", {27'd0, mole_onehot}, 32'h08);
    btn = 5'b01010;
    step();
    exp_miss = 1;
    check("combo_miss", {31'd0, miss}, 32'd1);
    check("combo_no_hit", {31'd0, hit}, 32'd0);
    check("misses_1", {28'd0, misses}, 32'd1);
    check("combo_score", {24'd0, score_tens, score_ones}, 32'h01);
    check("combo_armed", {30'd0, dbg_state}, {30'd0, S_ARMED});
    btn = 5'b00000;
    step();
    check("miss_one_cycle", {31'd0, miss}, 32'd0);
    btn = 5'b01000;
    step();
    exp_score = 2;
    check("hit3", {31'd0, hit}, 32'd1);
    check("score_0_2", {24'd0, score_tens, score_ones}, 32'h02);
    btn = 5'b00000;

    // Change in the same cycle as a correct press: relatch, no judgement.
    send_pos(3'd0);
    check("armed0_onehot", {27'd0, mole_onehot}, 32'h01);
    btn = 5'b00001;
    send_pos(3'd2);
    check("relatch_no_hitmiss", {30'd0, hit, miss}, 32'd0);
    check("relatch_onehot", {27'd0, mole_onehot}, 32'h04);
    btn = 5'b00000;
    step();

    // 100 hits; BCD tracking and saturation at 99.
    for (int i = 0; i < 100; i++) begin
      btn = 5'b00100;
      step();
      if (exp_score < 99) exp_score++;
      check("run_hit", {31'd0, hit}, 32'd1);
      check("run_score", {24'd0, score_tens, score_ones},
            {24'd0, 4'(exp_score / 10), 4'(exp_score % 10)});
      btn = 5'b00000;
      send_pos(3'd2);
    end

    // 16 wrong presses; miss count saturates at 15.
    for (int i = 0; i < 16; i++) begin
      btn = 5'b00001;
      step();
      if (exp_miss < 15) exp_miss++;
      check("run_miss", {31'd0, miss}, 32'd1);
      check("run_misses", {28'd0, misses}, exp_miss);
      btn = 5'b00000;
      step();
    end

    // No-mole position while ARMED returns to IDLE.
    send_pos(3'd5);
    check("nomole_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("nomole_onehot", {26'd0, mole_valid, mole_onehot}, 32'd0);
    btn = 5'b00001;
    step();
    check("idle_ignore_press", {30'd0, hit, miss}, 32'd0);
    btn = 5'b00000;

    // Asynchronous reset in WAIT_NEW.
    send_pos(3'd1);
    btn = 5'b00010;
    step();
    check("pre_reset_hit", {31'd0, hit}, 32'd1);
    btn = 5'b00000;
    step();
    check("pre_reset_wait", {30'd0, dbg_state}, {30'd0, S_WAIT});
    rst_n = 1'b0;
    #2;
    check("async_reset_outs", all_outs(), 32'd0);
    check("async_reset_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    #1;
    rst_n = 1'b1;
    step();
    send_pos(3'd4);
    check("restart_onehot", {27'd0, mole_onehot}, 32'h10);
    check("restart_score", {24'd0, score_tens, score_ones}, 32'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mole_hit_judge.md
# mole_hit_judge

Consumer side of the mole-position interface in the whack-a-mole game. Tracks the currently displayed mole from the position generator's position/changed outputs and judges the five debounced player buttons against it. Drives the one-hot mole LEDs, scores hits and misses, and on a hit issues the one-cycle change-position request back to the generator. Sits between the mole position generator, the debounced button block and the score display driver.

## Interface
- TIMEOUT, 16'd1000 — cycles to wait in WAIT_NEW for a new position before re-issuing the change request; legal range 1..65535.
- i_clk  input  1  system clock (100 MHz on board)
- i_rst_n  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low
- i_mole_position  input  3  generator's mole index; 0..4 valid, 5..7 means no mole
- i_position_changed  input  1  one-cycle pulse; i_mole_position is valid in the same cycle
- i_btn  input  5  debounced, synchronised button levels; bit k = hole k
- o_change_position  output  1  one-cycle request to the generator for a new position
- o_mole_onehot  output  5  LED drive; bit of the latched position while a mole is up, else 0
- o_mole_valid  output  1  high in ARMED only
- o_hit  output  1  one-cycle pulse per scored hit
- o_miss  output  1  one-cycle pulse per wrong press
- o_score_tens  output  4  BCD tens of the hit count
- o_score_ones  output  4  BCD ones of the hit count
- o_misses  output  4  binary miss count, saturates at 15

## Operation
- Button edges: btn_q holds the previous cycle's i_btn; rise = i_btn & ~btn_q. btn_q resets to 5'b11111, so a button held through reset produces no edge.
- Latched position pos_q (3 bits). Reset value 0; it is meaningful only in ARMED.
- States: IDLE, ARMED, WAIT_NEW. Reset state is IDLE.
- IDLE:
  - Outputs: mole_valid = 0, onehot = 0. Presses are ignored.
  - On i_position_changed with position < 5: latch pos_q and go to ARMED.
- ARMED:
  - Priority 1: i_position_changed. Relatch if position < 5, otherwise go to IDLE. Any rise in the same cycle is ignored.
  - Priority 2: rise == (1 << pos_q) exactly. This is a hit: pulse o_hit and o_change_position, increment the score, go to WAIT_NEW.
  - Priority 3: rise != 0 but not an exact match. This includes the correct button pressed together with a wrong one. This is a miss: pulse o_miss, increment o_misses (saturating), stay in ARMED.
- WAIT_NEW:
  - Outputs: mole_valid = 0, onehot = 0. Presses are ignored.
  - A 16-bit timer is cleared on entry.
  - On i_position_changed: position < 5 goes to ARMED (latch pos_q); otherwise go to IDLE.
  - If timer reaches TIMEOUT-1 with no change seen: pulse o_change_position again, clear the timer, remain in WAIT_NEW.
  - If i_position_changed arrives in the same cycle as the timeout, the change wins and no request is issued.
- Score:
  - BCD increment: if ones == 9, ones becomes 0 and tens increments; otherwise ones increments.
  - The count saturates at 99; o_hit still pulses once saturated.
- Reset values:
  - All outputs are 0.
  - Score is 0/0 and o_misses is 0.
  - Timer is 0.
  - Reset asserted mid-game returns to IDLE immediately (asynchronously) and clears the score.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- Press to response:
  - i_btn first sampled high at edge N (btn_q low).
  - o_hit / o_miss / o_change_position are high from edge N to N+1 only.
  - The score updates at edge N.
- Generator round trip:
  - The generator samples the request at N+1 and pulses changed after N+1.
  - This block samples changed at N+2, with ARMED and the new onehot visible after N+2.
- o_mole_onehot and o_mole_valid update on the same edge as the state change.
- A held button yields exactly one edge. A re-press needs at least one low sample.
- Pulse outputs are never high for two consecutive cycles from a single event. Repeated timeout requests are TIMEOUT cycles apart.

## Test plan
- Reset with i_btn = 5'b00100 held, then changed pulse with position 2 → ARMED, onehot 5'b00100, no hit until the button is released and pressed again; the re-press gives one o_hit pulse, score 0/1, o_change_position for exactly 1 cycle.
- ARMED at position 3, press buttons 1 and 3 together → o_miss pulse, o_misses = 1, score unchanged, still ARMED; then press 3 alone → hit.
- Hit, with no changed pulse for TIMEOUT = 4 → o_change_position pulses at 4-cycle spacing in WAIT_NEW; presses during WAIT_NEW produce no hit or miss.
- Changed pulse with position 2 in the same cycle as a button-0 rise while ARMED at 0 → relatch to 2, no hit, no miss.
- 100 consecutive hits → score tracks BCD (0/9 → 1/0, …) and saturates at 9/9; 16+ misses saturate o_misses at 15.
- Changed pulse with position 5 while ARMED → IDLE, onehot 0; assert i_rst_n low mid-WAIT_NEW → every output is 0 asynchronously and the block restarts in IDLE.
